// File: rtl/wb_sram_arbiter.sv
// Round-robin Wishbone arbiter that lets three masters share one SRAM controller port.
// A grant is held until its master drops cyc, or is rotated after max_xfers acks when another master is waiting.
module wb_sram_arbiter #(
  parameter int unsigned max_xfers = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_adr_i,
  input  logic [3:0]  m2_sel_i,
  input  logic [31:0] m2_dat_i,
  output logic        m2_ack_o,
  output logic [31:0] m_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o,
  output logic        gnt_valid_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;
  logic [2:0]  count_q, count_d;

  logic [2:0]  cyc_vec, req;
  logic [2:0]  gnt_onehot, others_req;
  logic        granted, limit_hit;
  logic [2:0]  count_inc;
  logic        sel_cyc, sel_stb, sel_we;
  logic [31:0] sel_adr, sel_dat;
  logic [3:0]  sel_sel;

  assign cyc_vec    = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign req        = cyc_vec & {m2_stb_i, m1_stb_i, m0_stb_i};
  assign granted    = (state_q == GRANT);
  assign gnt_onehot = 3'b001 << gnt_q;
  assign others_req = req & ~gnt_onehot;
  assign count_inc  = (count_q == 3'd7) ? 3'd7 : count_q + 3'd1;
  assign limit_hit  = (max_xfers != 0) && ((32'(count_q) + 32'd1) >= max_xfers);

  // Search starts just after the last released master, so ties never favour a fixed index.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
    logic [1:0] pick;
    pick = 2'd0;
    for (int j = 2; j >= 0; j--) begin
      if (r[(int'(last) + 1 + j) % 3]) pick = 2'((int'(last) + 1 + j) % 3);
    end
    return pick;
  endfunction

  always_comb begin
    sel_cyc = m0_cyc_i;
    sel_stb = m0_stb_i;
    sel_we  = m0_we_i;
    sel_adr = m0_adr_i;
    sel_sel = m0_sel_i;
    sel_dat = m0_dat_i;
    case (gnt_q)
      2'd1: begin
        sel_cyc = m1_cyc_i;
        sel_stb = m1_stb_i;
        sel_we  = m1_we_i;
        sel_adr = m1_adr_i;
        sel_sel = m1_sel_i;
        sel_dat = m1_dat_i;
      end
      2'd2: begin
        sel_cyc = m2_cyc_i;
        sel_stb = m2_stb_i;
        sel_we  = m2_we_i;
        sel_adr = m2_adr_i;
        sel_sel = m2_sel_i;
        sel_dat = m2_dat_i;
      end
      default: ;
    endcase
  end

  assign s_cyc_o     = granted & sel_cyc;
  assign s_stb_o     = granted & sel_cyc & sel_stb;
  assign s_we_o      = granted & sel_we;
  assign s_adr_o     = sel_adr;
  assign s_sel_o     = sel_sel;
  assign s_dat_o     = sel_dat;
  assign m_dat_o     = s_dat_i;
  assign gnt_o       = gnt_q;
  assign gnt_valid_o = granted;

  // Acks arriving after a release (state IDLE) are dropped here.
  assign m0_ack_o = s_ack_i & granted & (gnt_q == 2'd0);
  assign m1_ack_o = s_ack_i & granted & (gnt_q == 2'd1);
  assign m2_ack_o = s_ack_i & granted & (gnt_q == 2'd2);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = rr_pick(last_q, req);
          count_d = 3'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (s_ack_i) count_d = count_inc;
        if (!sel_cyc || (s_ack_i && limit_hit && (|others_req))) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      last_q  <= 2'd2;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Directed testbench for wb_sram_arbiter: reset, single access, round robin, forced rotation,
// long bursts without a competitor, cyc abort with a late ack, and reset during a transfer.
module tb_wb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cyc, stb, we;
  logic [31:0] adr [3];
  logic [3:0]  sel [3];
  logic [31:0] dat [3];
  logic        m0_ack_o, m1_ack_o, m2_ack_o;
  logic [31:0] m_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;
  logic        gnt_valid_o;
  logic [2:0]  acks;

  int n_checks = 0;
  int n_fail   = 0;

  assign acks = {m2_ack_o, m1_ack_o, m0_ack_o};

  always #5 clk = ~clk;

  wb_sram_arbiter #(.max_xfers(4)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_sel_i(sel[0]), .m0_dat_i(dat[0]), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_sel_i(sel[1]), .m1_dat_i(dat[1]), .m1_ack_o(m1_ack_o),
    .m2_cyc_i(cyc[2]), .m2_stb_i(stb[2]), .m2_we_i(we[2]), .m2_adr_i(adr[2]),
    .m2_sel_i(sel[2]), .m2_dat_i(dat[2]), .m2_ack_o(m2_ack_o),
    .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .gnt_valid_o(gnt_valid_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    cyc = 3'b000;
    stb = 3'b000;
    we  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      adr[i] = 32'h1000 * (i + 1);
      sel[i] = 4'hF;
      dat[i] = 32'hA000_0000 + i;
    end
    s_ack_i = 1'b0;
    s_dat_i = 32'h0;
  endtask

  task automatic do_reset();
    clear_masters();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_masters();
    reset = 1'b1;
    cyc[2] = 1'b1;
    stb[2] = 1'b1;
    tick();
    tick();
    s_ack_i = 1'b1;
    #1;
    n_checks++;
    if (gnt_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_valid: got %b expected 0", gnt_valid_o); end
    n_checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_s_cyc_stb: got %b%b expected 00", s_cyc_o, s_stb_o); end
    n_checks++;
    if (gnt_o !== 2'd0) begin n_fail++; $display("FAIL reset_gnt: got %0d expected 0", gnt_o); end
    n_checks++;
    if (acks !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b expected 000", acks); end
    clear_masters();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h100;
    #1;
    n_checks++;
    if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL single_stb_idle: got %b expected 0", s_stb_o); end
    tick();
    n_checks++;
    if (gnt_o !== 2'd1 || gnt_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %0d/%b expected 1/1", gnt_o, gnt_valid_o); end
    n_checks++;
    if (s_stb_o !== 1'b1 || s_adr_o !== 32'h100 || s_we_o !== 1'b0) begin
      n_fail++; $display("FAIL single_slave_bus: got stb=%b adr=%h we=%b expected 1/100/0", s_stb_o, s_adr_o, s_we_o);
    end
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (acks !== 3'b010) begin n_fail++; $display("FAIL single_ack: got %b expected 010", acks); end
    n_checks++;
    if (m_dat_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h expected deadbeef", m_dat_o); end
    tick();
    s_ack_i = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    tick();
    n_checks++;
    if (gnt_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b expected 0", gnt_valid_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    cyc = 3'b111; stb = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (gnt_o !== 2'(i) || gnt_valid_o !== 1'b1 || s_adr_o !== adr[i]) begin
        n_fail++; $display("FAIL rr_gnt%0d: got gnt=%0d valid=%b adr=%h expected %0d/1/%h", i, gnt_o, gnt_valid_o, s_adr_o, i, adr[i]);
      end
      s_ack_i = 1'b1;
      #1;
      n_checks++;
      if (acks !== (3'b001 << i)) begin n_fail++; $display("FAIL rr_ack%0d: got %b expected %b", i, acks, 3'b001 << i); end
      tick();
      s_ack_i = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
      tick();
      n_checks++;
      if (gnt_valid_o !== 1'b0) begin n_fail++; $display("FAIL rr_idle%0d: got %b expected 0", i, gnt_valid_o); end
    end
  endtask

  task automatic test_forced_release();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    tick();
    for (int w = 1; w <= 4; w++) begin
      if (w == 2) begin cyc[2] = 1'b1; stb[2] = 1'b1; end
      #1;
      n_checks++;
      if (gnt_o !== 2'd0 || s_stb_o !== 1'b1 || s_we_o !== 1'b1) begin
        n_fail++; $display("FAIL forced_write%0d: got gnt=%0d stb=%b we=%b expected 0/1/1", w, gnt_o, s_stb_o, s_we_o);
      end
      tick();
      s_ack_i = 1'b1;
      #1;
      n_checks++;
      if (acks !== 3'b001) begin n_fail++; $display("FAIL forced_ack%0d: got %b expected 001", w, acks); end
      tick();
      s_ack_i = 1'b0;
    end
    #1;
    n_checks++;
    if (gnt_valid_o !== 1'b0 || s_stb_o !== 1'b0) begin
      n_fail++; $display("FAIL forced_release: got valid=%b stb=%b expected 0/0", gnt_valid_o, s_stb_o);
    end
    tick();
    n_checks++;
    if (gnt_o !== 2'd2 || gnt_valid_o !== 1'b1) begin n_fail++; $display("FAIL forced_m2_gnt: got %0d/%b expected 2/1", gnt_o, gnt_valid_o); end
    s_ack_i = 1'b1;
    #1;
    n_checks++;
    if (acks !== 3'b100) begin n_fail++; $display("FAIL forced_m2_ack: got %b expected 100", acks); end
    tick();
    s_ack_i = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
    tick();
    tick();
    n_checks++;
    if (gnt_o !== 2'd0 || gnt_valid_o !== 1'b1) begin n_fail++; $display("FAIL forced_m0_regain: got %0d/%b expected 0/1", gnt_o, gnt_valid_o); end
    clear_masters();
    tick();
    tick();
  endtask

  task automatic test_no_competitor();
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    tick();
    for (int w = 1; w <= 10; w++) begin
      #1;
      n_checks++;
      if (gnt_o !== 2'd0 || gnt_valid_o !== 1'b1 || s_stb_o !== 1'b1) begin
        n_fail++; $display("FAIL solo_write%0d: got gnt=%0d valid=%b stb=%b expected 0/1/1", w, gnt_o, gnt_valid_o, s_stb_o);
      end
      tick();
      s_ack_i = 1'b1;
      #1;
      n_checks++;
      if (acks !== 3'b001) begin n_fail++; $display("FAIL solo_ack%0d: got %b expected 001", w, acks); end
      tick();
      s_ack_i = 1'b0;
    end
    #1;
    n_checks++;
    if (gnt_valid_o !== 1'b1) begin n_fail++; $display("FAIL solo_still_granted: got %b expected 1", gnt_valid_o); end
    clear_masters();
    tick();
    tick();
  endtask

  task automatic test_cyc_drop();
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    n_checks++;
    if (s_stb_o !== 1'b1 || gnt_o !== 2'd1) begin n_fail++; $display("FAIL drop_granted: got stb=%b gnt=%0d expected 1/1", s_stb_o, gnt_o); end
    tick();
    cyc[1] = 1'b0; stb[1] = 1'b0;
    #1;
    n_checks++;
    if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL drop_s_cyc: got %b expected 0", s_cyc_o); end
    tick();
    s_ack_i = 1'b1;
    #1;
    n_checks++;
    if (acks !== 3'b000 || gnt_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL drop_late_ack: got acks=%b valid=%b expected 000/0", acks, gnt_valid_o);
    end
    tick();
    s_ack_i = 1'b0;
    #1;
    n_checks++;
    if (gnt_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_stay_idle: got %b expected 0", gnt_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
    tick();
    n_checks++;
    if (gnt_o !== 2'd2 || s_stb_o !== 1'b1) begin n_fail++; $display("FAIL rmid_m2_gnt: got %0d/%b expected 2/1", gnt_o, s_stb_o); end
    cyc[0] = 1'b1; stb[0] = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (s_cyc_o !== 1'b0 || gnt_valid_o !== 1'b0 || gnt_o !== 2'd0) begin
      n_fail++; $display("FAIL rmid_reset: got cyc=%b valid=%b gnt=%0d expected 0/0/0", s_cyc_o, gnt_valid_o, gnt_o);
    end
    tick();
    n_checks++;
    if (gnt_o !== 2'd0 || gnt_valid_o !== 1'b1) begin n_fail++; $display("FAIL rmid_tie: got %0d/%b expected 0/1", gnt_o, gnt_valid_o); end
    clear_masters();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear_masters();
    test_reset();
    test_single();
    test_round_robin();
    test_forced_release();
    test_no_competitor();
    test_cyc_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_sram_arbiter.md
WB_SRAM_ARBITER -- requirements
Module: wb_sram_arbiter

Interface
REQ-001 Parameter max_xfers, default 4, meaning acks per grant before forced rotation when others wait; 0 = unlimited.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 mK_cyc_i  input  1  cycle of master K (K=0..2).
REQ-005 mK_stb_i  input  1  strobe of master K.
REQ-006 mK_we_i  input  1  write enable of master K.
REQ-007 mK_adr_i  input  32  address of master K.
REQ-008 mK_sel_i  input  4  byte selects of master K.
REQ-009 mK_dat_i  input  32  write data of master K.
REQ-010 mK_ack_o  output  1  ack to master K.
REQ-011 m_dat_o  output  32  read data, shared by all masters.
REQ-012 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave-side control to SRAM controller.
REQ-013 s_adr_o  output  32  slave address.
REQ-014 s_sel_o  output  4  slave byte selects.
REQ-015 s_dat_o  output  32  slave write data.
REQ-016 s_dat_i  input  32  slave read data.
REQ-017 s_ack_i  input  1  slave ack (registered, one-cycle pulse).
REQ-018 gnt_o  output  2  index of granted master.
REQ-019 gnt_valid_o  output  1  high in GRANT state.

Function
REQ-020 States: IDLE, GRANT; req[K] = mK_cyc_i & mK_stb_i.
REQ-021 IDLE: if any req, SHALL register gnt = first requester searching round-robin from last+1 (mod 3), clear xfer count, enter GRANT next cycle; else stay.
REQ-022 Arbitration latency: exactly one cycle from req to s_stb_o high.
REQ-023 GRANT: s_cyc_o = m[gnt]_cyc_i; s_stb_o = m[gnt]_cyc_i & m[gnt]_stb_i; s_we/adr/sel/dat_o combinationally muxed from m[gnt].
REQ-024 IDLE: s_cyc_o = s_stb_o = 0; s_we_o = 0; adr/sel/dat_o driven from m[gnt] (don't care).
REQ-025 mK_ack_o = s_ack_i & (state == GRANT) & (gnt == K); never asserted to non-granted master.
REQ-026 m_dat_o = s_dat_i unconditionally.
REQ-027 Each s_ack_i in GRANT SHALL increment 3-bit xfer count (saturating at 7).
REQ-028 Release: GRANT -> IDLE next cycle when m[gnt]_cyc_i = 0 (last := gnt).
REQ-029 Forced release: max_xfers != 0, s_ack_i high, count+1 >= max_xfers, and another master's req high -> IDLE next cycle, last := gnt; no new strobe forwarded from released master after that ack.
REQ-030 Forced release SHALL NOT occur when no other master requests; grant persists with count saturating.
REQ-031 cyc drop mid-transfer (stb high, no ack yet): release per REQ-028; a late s_ack_i in IDLE SHALL be discarded (no mK_ack_o).
REQ-032 Simultaneous requests in IDLE resolved only by round-robin pointer; no fixed priority.
REQ-033 gnt_o and state only change on clock edge; outputs glitch-free relative to registered state.

Reset
REQ-034 reset SHALL force state IDLE, gnt = 0, last = 2 (m0 first), count = 0 within one cycle, overriding any in-flight transfer; s_cyc_o, s_stb_o, all mK_ack_o, gnt_valid_o = 0 during and after reset until REQ-021.

Verification
REQ-035 Single: m1 read adr 0x100 after reset -> gnt_o=1 next cycle, s_stb_o one cycle after req, m1_ack_o on s_ack_i, m_dat_o = s_dat_i.
REQ-036 Simultaneous m0,m1,m2 single reads from reset -> grants in order 0,1,2, one IDLE cycle between each.
REQ-037 max_xfers=4, m0 holds cyc for 10 writes, m2 requests at write 2 -> m0 released after 4th ack, m2 granted, m0 regains after m2 drops cyc.
REQ-038 Same as REQ-037 with no competitor -> m0 completes all 10 writes in one grant.
REQ-039 m1 drops cyc before ack; slave acks next cycle -> no mK_ack_o pulse, state IDLE.
REQ-040 reset asserted during m2 write stb -> next cycle s_cyc_o=0, gnt_valid_o=0; after release m0 wins tie against m2.
